// File: rtl/slow_tick_timer_if.sv
// Control/status bundle for slow_tick_timer: countdown commands in, count and pulses out.
interface slow_tick_timer_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             start;
    logic [WIDTH-1:0] load_value;
    logic             hold;
    logic             cancel;
    logic [WIDTH-1:0] remaining;
    logic             busy;
    logic             held;
    logic             tick;
    logic             done;

    modport master (
        output start, load_value, hold, cancel,
        input  remaining, busy, held, tick, done
    );

    modport slave (
        input  start, load_value, hold, cancel,
        output remaining, busy, held, tick, done
    );
endinterface

// File: rtl/slow_tick_timer.sv
// Countdown timer clocked by ticks derived from a slow divided clock sampled as data.
// Supports start, hold (pause), cancel and a one-cycle done pulse.
module slow_tick_timer #(
    parameter int unsigned WIDTH      = 16,
    parameter bit          BOTH_EDGES = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             slow_clk,
    slow_tick_timer_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic             done_q, done_d;
    logic             tick_q, tick_d;
    logic             s1_q, s2_q, s3_q;
    logic             rise, fall;

    // s1/s2 resynchronize the asynchronous slow clock; s3 holds the previous value.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= slow_clk;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise   = s2_q & ~s3_q;
    assign fall   = ~s2_q & s3_q;
    assign tick_d = rise | (BOTH_EDGES & fall);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.load_value != '0) begin
                        state_d     = StRun;
                        remaining_d = bus.load_value;
                    end else begin
                        remaining_d = '0;
                        done_d      = 1'b1;
                    end
                end
            end
            StRun: begin
                // Priority: cancel, then hold (same-edge tick dropped), then tick.
                if (bus.cancel) begin
                    state_d     = StIdle;
                    remaining_d = '0;
                end else if (bus.hold) begin
                    state_d = StHold;
                end else if (tick_q) begin
                    if (remaining_q > WIDTH'(1)) begin
                        remaining_d = remaining_q - WIDTH'(1);
                    end else begin
                        remaining_d = '0;
                        done_d      = 1'b1;
                        state_d     = StIdle;
                    end
                end
            end
            StHold: begin
                if (bus.cancel) begin
                    state_d     = StIdle;
                    remaining_d = '0;
                end else if (!bus.hold) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d     = StIdle;
                remaining_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            done_q      <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
            tick_q      <= tick_d;
        end
    end

    assign bus.remaining = remaining_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.held      = (state_q == StHold);
    assign bus.tick      = tick_q;
    assign bus.done      = done_q;

endmodule

// File: doc/slow_tick_timer.md
Name: slow_tick_timer

Overview:
- Consumer end of the divided-clock path. Takes a slow toggling clock from the clock divider (e.g. 10 ms half-period) as a plain data input in the system `clk` domain.
- Synchronizes and edge-detects that input into single-cycle ticks, then counts a programmable number of ticks down to zero.
- Used by the kitchen-helper control logic for cook/alarm countdowns: start, hold (pause), cancel, done pulse.

Parameters:
- WIDTH, 16, width of load value and remaining count.
- BOTH_EDGES, 0: 0 = one tick per slow_clk rising edge; 1 = one tick per rising and per falling edge.

Ports:
- clk  input  1  system clock (50 MHz)
- rst  input  1  synchronous, active-high reset
- slow_clk  input  1  divided clock from divider; asynchronous to logic, treated as data
- start  input  1  level, sampled per cycle; begins countdown in IDLE only
- load_value  input  WIDTH  tick count latched when start accepted
- hold  input  1  level; while high in RUN, counting frozen
- cancel  input  1  level, sampled per cycle; aborts countdown
- remaining  output  WIDTH  current remaining ticks
- busy  output  1  high in RUN or HOLD
- held  output  1  high in HOLD
- tick  output  1  registered one-cycle pulse per detected slow_clk edge; free-running in every state
- done  output  1  one-cycle pulse when countdown reaches 0

Behaviour:
- Clocking and reset:
  - One clock `clk`. Reset `rst` is synchronous and active-high.
  - Reset values: remaining=0, busy=0, held=0, tick=0, done=0, state=IDLE, sync flops=0, edge-history flop=0.
- Edge detect:
  - 2-flop synchronizer s1→s2, then history flop s3.
  - Rise = s2 & ~s3. Fall = ~s2 & s3.
  - tick is registered: `tick <= rise | (BOTH_EDGES & fall)`.
  - A slow_clk transition meeting setup before clk edge N gives tick high during cycle N+3.
- After reset, a slow_clk already high yields one rising tick. This is accepted behaviour and is harmless outside RUN.
- Counting uses the registered tick: the decrement happens on the clk edge where tick=1, so remaining changes one cycle after tick is visible.
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - start=1 and load_value≠0 → RUN; remaining<=load_value; busy=1 next cycle.
  - start=1 and load_value=0 → stay IDLE; remaining<=0; done pulses next cycle.
  - cancel, hold, and tick have no effect.
- RUN (per-edge priority: cancel > hold > tick):
  - cancel=1 → IDLE; remaining<=0; no done.
  - hold=1 → HOLD; a tick on the same edge is discarded.
  - tick=1 and remaining>1 → remaining-1.
  - tick=1 and remaining==1 → remaining<=0; done<=1; → IDLE.
  - start is ignored; no reload.
- HOLD:
  - cancel=1 → IDLE; remaining<=0; no done.
  - hold=0 → RUN; count resumes from the held value.
  - Ticks arriving while in HOLD are discarded, not queued.
- done is high for exactly one cycle, in the same cycle remaining first reads 0 and busy reads 0.
- busy and held are registered state decodes. No combinational path from any input to any output.
- No wrap-around: remaining never decrements below 0 and never wraps.
- Reset mid-countdown: next cycle, all outputs return to reset values. No done pulse.
- start asserted in the same cycle done is high: state is IDLE, so the start is accepted and a new countdown begins.

Test Plan:
- Reset, slow_clk low, 8-cycle period (toggle every 4 clk) → tick pulses every 8 cycles, one cycle wide, 3 cycles after each rise. With BOTH_EDGES=1, every 4 cycles.
- start with load_value=3 → busy=1 next cycle. remaining steps 3→2→1→0, one cycle after each tick. done is one cycle wide, coincident with remaining=0 and busy=0.
- load_value=5, hold=1 after 2 ticks for 3 slow periods → remaining stays 3, held=1. On release, counts 3→2→1→0. Total done latency = 5 counted ticks plus the hold duration.
- load_value=4, cancel asserted in the same cycle as a tick at remaining=2 → remaining=0, IDLE, no done, no decrement to 1.
- start with load_value=0 → done pulses next cycle, busy never asserts. Separately, start re-pulsed during RUN → ignored, remaining unchanged.
- rst asserted mid-countdown at remaining=7 → next cycle remaining=0, busy=0, tick=0, done=0. A slow_clk high at reset release gives exactly one tick.
